// File: rtl/bb84_pkg.sv
// Shared definitions for the BB84 link model: basis encodings, LFSR taps,
// the qubit record and the LFSR next-state helper.
package bb84_pkg;

   localparam logic BASIS_RECT = 1'b0;
   localparam logic BASIS_DIAG = 1'b1;

   localparam int          LFSR_W_DEF = 16;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form: bits 0,2,3,5
   localparam logic [15:0] LFSR_TAPS  = 16'h002D;

   typedef struct packed {
      logic data;
      logic basis;
   } qubit_t;

   function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
      lfsr16_next = {^(state & LFSR_TAPS), state[15:1]};
   endfunction

endpackage

// File: rtl/bb84_lfsr.sv
// Free-running Fibonacci LFSR; shifts once per non-reset cycle and exposes
// its current (pre-shift) state as the random word.
module bb84_lfsr
   import bb84_pkg::*;
#(
   parameter int                WIDTH = 16,
   parameter logic [WIDTH-1:0]  SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] rnd
);

   // An all-zero state would lock the register, so a zero seed becomes 1.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   localparam logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS);

   logic [WIDTH-1:0] r_lfsr;
   logic             w_feedback;

   // Feedback bit from the tapped positions of the current state.
   always_comb begin
      w_feedback = ^(r_lfsr & TAPS);
   end

   // State register: reload the seed on reset, otherwise shift right.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= SEED_EFF;
      end else begin
         r_lfsr <= {w_feedback, r_lfsr[WIDTH-1:1]};
      end
   end

   assign rnd = r_lfsr;

endmodule

// File: rtl/bb84_top_module.sv
// BB84 link model: Alice encodes, Eve optionally intercepts and resends,
// Bob measures; one registered output stage carries qubit, a1 and error.
module bb84_top_module
   import bb84_pkg::*;
#(
   parameter int                 LFSR_W    = 16,
   parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       b1,
   input  logic       spy,
   output logic [1:0] qubit,
   output logic       a1,
   output logic       error
);

   logic [LFSR_W-1:0] w_rnd;
   logic              w_r0;
   logic              w_r1;
   logic              w_r2;
   logic              w_cb;
   logic              w_cv;
   logic              w_a1_next;
   logic              w_err_next;

   qubit_t            r_qubit;
   logic              r_a1;
   logic              r_error;

   bb84_lfsr #(
      .WIDTH (LFSR_W),
      .SEED  (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (w_rnd)
   );

   assign w_r0 = w_rnd[0];
   assign w_r1 = w_rnd[1];
   assign w_r2 = w_rnd[2];

   // Channel: Eve measures in a random basis and resends her own result.
   always_comb begin
      w_cb = b;
      w_cv = a;
      if (spy) begin
         w_cb = w_r1;
         if (w_r1 == b) begin
            w_cv = a;
         end else begin
            w_cv = w_r2;
         end
      end else begin
         w_cb = b;
         w_cv = a;
      end
   end

   // Bob: a matching basis reads the channel value, otherwise a coin flip.
   always_comb begin
      w_a1_next = w_r0;
      if (b1 == w_cb) begin
         w_a1_next = w_cv;
      end else begin
         w_a1_next = w_r0;
      end
   end

   // Errors are only meaningful on sifted cycles where Alice and Bob agree.
   always_comb begin
      w_err_next = 1'b0;
      if (b == b1) begin
         w_err_next = (w_a1_next != a);
      end else begin
         w_err_next = 1'b0;
      end
   end

   // Output stage; reset takes priority over the cycle's transmission.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_qubit <= '{data: 1'b0, basis: BASIS_RECT};
         r_a1    <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_qubit <= '{data: a, basis: b};
         r_a1    <= w_a1_next;
         r_error <= w_err_next;
      end
   end

   assign qubit = r_qubit;
   assign a1    = r_a1;
   assign error = r_error;

endmodule

// File: tb/tb_bb84_top_module.sv
// Directed and pseudo-random checks of bb84_top_module against an
// independent reference LFSR and channel model, via a scoreboard queue.
module tb_bb84_top_module;

   localparam logic [15:0] SEED = 16'hACE1;

   typedef struct packed {
      logic [1:0] qubit;
      logic       a1;
      logic       error;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       a;
   logic       b;
   logic       b1;
   logic       spy;
   logic [1:0] qubit;
   logic       a1;
   logic       error;

   int          checks;
   int          errors;
   logic [15:0] m_lfsr;
   logic        m_r1_last;
   exp_t        sb[$];
   string       tags[$];

   bb84_top_module #(
      .LFSR_W    (16),
      .LFSR_SEED (SEED)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .b1    (b1),
      .spy   (spy),
      .qubit (qubit),
      .a1    (a1),
      .error (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model_shift(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   // Drive one cycle, push the model's prediction, then pop and compare.
   task automatic step(input logic ir, input logic ia, input logic ib,
                       input logic ib1, input logic ispy, input string tag);
      exp_t        e;
      exp_t        got;
      string       t;
      logic        eb;
      logic        cb;
      logic        cv;
      logic        ea1;
      logic [15:0] nxt;
      rst = ir; a = ia; b = ib; b1 = ib1; spy = ispy;
      m_r1_last = m_lfsr[1];
      if (ir) begin
         e   = '{qubit: 2'b00, a1: 1'b0, error: 1'b0};
         nxt = SEED;
      end else begin
         eb  = m_lfsr[1];
         cb  = ispy ? eb : ib;
         cv  = ispy ? ((eb == ib) ? ia : m_lfsr[2]) : ia;
         ea1 = (ib1 == cb) ? cv : m_lfsr[0];
         e   = '{qubit: {ia, ib}, a1: ea1, error: ((ib == ib1) && (ea1 != ia))};
         nxt = model_shift(m_lfsr);
      end
      sb.push_back(e);
      tags.push_back(tag);
      @(posedge clk);
      m_lfsr = nxt;
      #1;
      got = sb.pop_front();
      t   = tags.pop_front();
      checks++;
      assert (qubit === got.qubit) else begin
         errors++;
         $error("FAIL %s qubit observed %b expected %b", t, qubit, got.qubit);
      end
      checks++;
      assert (a1 === got.a1) else begin
         errors++;
         $error("FAIL %s a1 observed %b expected %b", t, a1, got.a1);
      end
      checks++;
      assert (error === got.error) else begin
         errors++;
         $error("FAIL %s error observed %b expected %b", t, error, got.error);
      end
   endtask

   initial begin
      int  err_cnt;
      logic ra;
      logic rb;
      checks = 0;
      errors = 0;
      m_lfsr = SEED;
      rst = 1'b1; a = 1'b0; b = 1'b0; b1 = 1'b0; spy = 1'b0;

      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "reset0");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "reset1");
      checks++;
      assert (dut.w_rnd === 16'hACE1) else begin
         errors++;
         $error("FAIL seed observed %h expected %h", dut.w_rnd, 16'hACE1);
      end

      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "nospy_a1b0");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "nospy_a0b1");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, i[1], i[0], i[0], 1'b0, "nospy_match");
         checks++;
         assert (a1 === i[1] && error === 1'b0) else begin
            errors++;
            $error("FAIL nospy_guarantee observed a1=%b err=%b expected a1=%b err=0", a1, error, i[1]);
         end
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "nospy_mismatch");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "nospy_mismatch2");

      // Eavesdropped sifted cycles: about a quarter should show an error.
      err_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         ra = 1'($urandom_range(1, 0));
         rb = 1'($urandom_range(1, 0));
         step(1'b0, ra, rb, rb, 1'b1, "spy_rand");
         if (error) begin
            err_cnt++;
            checks++;
            assert (m_r1_last !== rb) else begin
               errors++;
               $error("FAIL spy_err_basis observed eb=%b expected differs from b=%b", m_r1_last, rb);
            end
         end
      end
      checks++;
      assert (err_cnt >= 200 && err_cnt <= 300) else begin
         errors++;
         $error("FAIL spy_rate observed %0d expected 200..300", err_cnt);
      end

      // Mid-stream reset under spy: outputs clear and the sequence restarts.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pre_reset");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "mid_reset");
      checks++;
      assert (dut.w_rnd === 16'hACE1) else begin
         errors++;
         $error("FAIL restart_seed observed %h expected %h", dut.w_rnd, 16'hACE1);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b0, i[0], i[1], i[1], 1'b1, "post_reset");
      end
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "post_reset_mis");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
